// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed common-cathode 7-segment driver.
// Frame-synchronous value update, dead-time blanking, BCD decode, LZ blanking.
module seg7_scan_driver #(
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int LZ_BLANK     = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [15:0] bcd_in,
   input  logic        bcd_valid,
   output logic        bcd_ready,
   input  logic        scan_en,
   output logic [6:0]  seven_seg,
   output logic [3:0]  digit_en,
   output logic        frame_tick
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   logic [15:0]   disp_q;
   logic [15:0]   pend_q;
   logic          pend_v;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;

   logic          slot_end;
   logic          frame_end;
   logic          accept;
   logic [3:0]    cur_nib;
   logic          lead_zero;
   logic          blank_digit;
   logic [6:0]    seg_dec;

   assign bcd_ready   = !pend_v;
   assign accept      = bcd_valid && !pend_v;
   assign slot_end    = (cnt == CNT_LAST);
   assign frame_end   = scan_en && slot_end && (idx == 2'd3);
   assign cur_nib     = disp_q[{idx, 2'b00} +: 4];
   assign blank_digit = (LZ_BLANK != 0) && lead_zero;

   // Slot counter and digit index; held at digit 0, cycle 0 while disabled.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (!scan_en) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Pending buffer; commits to the display only at a frame edge or while idle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         disp_q <= 16'h0000;
         pend_q <= 16'h0000;
         pend_v <= 1'b0;
      end else if (pend_v && (frame_end || !scan_en)) begin
         disp_q <= pend_q;
         pend_v <= 1'b0;
      end else if (accept) begin
         pend_q <= bcd_in;
         pend_v <= 1'b1;
      end
   end

   // Digit k is a leading zero when it and every digit left of it are zero.
   always_comb begin
      lead_zero = 1'b0;
      unique case (idx)
         2'd3:    lead_zero = (disp_q[15:12] == 4'h0);
         2'd2:    lead_zero = (disp_q[15:8] == 8'h00);
         2'd1:    lead_zero = (disp_q[15:4] == 12'h000);
         default: lead_zero = 1'b0;
      endcase
   end

   // BCD to {g,f,e,d,c,b,a}; codes above 9 show a dash.
   always_comb begin
      seg_dec = 7'h40;
      unique case (cur_nib)
         4'd0:    seg_dec = 7'h3F;
         4'd1:    seg_dec = 7'h06;
         4'd2:    seg_dec = 7'h5B;
         4'd3:    seg_dec = 7'h4F;
         4'd4:    seg_dec = 7'h66;
         4'd5:    seg_dec = 7'h6D;
         4'd6:    seg_dec = 7'h7D;
         4'd7:    seg_dec = 7'h07;
         4'd8:    seg_dec = 7'h7F;
         4'd9:    seg_dec = 7'h6F;
         default: seg_dec = 7'h40;
      endcase
   end

   // Registered pad outputs; dark during dead time and while disabled.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         seven_seg  <= 7'h00;
         digit_en   <= 4'h0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (!scan_en || (cnt < CNT_BLANK)) begin
            seven_seg <= 7'h00;
            digit_en  <= 4'h0;
         end else begin
            digit_en  <= 4'b0001 << idx;
            seven_seg <= blank_digit ? 7'h00 : seg_dec;
         end
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives a 4-digit multiplexed common-cathode seven-segment display from a packed 4-nibble BCD value.
- Sits downstream of the timer/counter logic and upstream of the user-area IO pads.
- Accepts new values through a valid/ready handshake and applies them only at frame boundaries, so no digit tears mid-frame.
- Generates the digit scan, dead-time blanking, BCD decode and optional leading-zero suppression.

Parameters:
- REFRESH_DIV, 1000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot with all outputs off (anti-ghosting); must be < REFRESH_DIV.
- LZ_BLANK, 1: 1 enables leading-zero suppression on digits 3..1.

Ports:
- wb_clk_i  input  1  single clock for the block.
- wb_rst_i  input  1  asynchronous, active-high reset; applies to every flop in the block.
- bcd_in  input  16  packed nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- bcd_valid  input  1  bcd_in is valid this cycle.
- bcd_ready  output  1  block can accept a value this cycle.
- scan_en  input  1  1 runs the scan; 0 holds the scan and blanks the display.
- seven_seg  output  7  active-high segments {g,f,e,d,c,b,a}.
- digit_en  output  4  active-high one-hot digit select; bit i selects digit i.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset: disp_q=0, pend_q=0, pend_v=0, cnt=0, idx=0.
  - Outputs after reset: seven_seg=0, digit_en=0, frame_tick=0, bcd_ready=1.
  - Reset asserted mid-frame clears all state immediately; any pending value is discarded.
- Handshake: bcd_ready = !pend_v, combinational from a flop.
  - When bcd_valid && bcd_ready: pend_q <= bcd_in and pend_v <= 1.
  - bcd_in is ignored whenever bcd_ready=0.
- Scan counters, active when scan_en=1:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap, idx advances 0->1->2->3->0.
  - A frame is 4*REFRESH_DIV cycles.
- Frame boundary: the cycle on which cnt wraps and idx goes 3->0.
  - On that edge, if pend_v=1: disp_q <= pend_q and pend_v <= 0.
  - frame_tick is registered and pulses high for the cycle after that edge.
  - A handshake accepted on the boundary cycle itself loads pend_q, because pend_v was already 0. That value is applied at the next boundary, not the current one.
- scan_en=0:
  - cnt and idx are forced to 0 and frame_tick=0.
  - Any pending value transfers to disp_q on the next edge.
  - seven_seg=0 and digit_en=0.
  - On re-enable, the scan restarts at digit 0, slot cycle 0.
- Outputs are registered and lag the (cnt, idx, disp_q) state by one cycle.
  - While cnt < BLANK_CYCLES: seven_seg=0 and digit_en=0.
  - Otherwise: digit_en = 1<<idx and seven_seg = decode(nibble idx of disp_q).
- Decode table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10..15 decode to dash 40 (segment g only).
- Leading-zero blanking, when LZ_BLANK=1:
  - Digit k (k=3..1) is blanked when nibbles 3..k of disp_q are all 0.
  - Digit 0 is never blanked.
  - A blanked digit gives seven_seg=0 but keeps its digit_en bit asserted, so timing is unchanged.
  - Non-zero non-BCD nibbles count as non-zero.
- Output exclusivity: at most one digit_en bit is high in any cycle, and never during dead time.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1 unless noted.
- Reset: assert wb_rst_i asynchronously mid-slot.
  - Same instant: seven_seg=0, digit_en=0, bcd_ready=1, frame_tick=0.
  - After release: the first lit slot is digit 0.
- Load 16'h1234 with scan_en=1.
  - After the next frame_tick, each slot shows 2 dark cycles, then 6 cycles of the digit: digit_en=0001 seg=66, 0010 seg=4F, 0100 seg=5B, 1000 seg=06.
  - frame_tick repeats every 32 cycles.
- Leading-zero suppression, load 16'h0050.
  - Digits 3 and 2: digit_en asserted with seven_seg=00.
  - Digit 1 seg=6D; digit 0 seg=3F.
  - Rerun with LZ_BLANK=0: digits 3 and 2 show 3F.
- Backpressure: present 16'h1111, then 16'h2222 back to back, mid-frame.
  - 1111 is accepted and bcd_ready drops.
  - 2222 stalls until the cycle after the boundary.
  - The display changes only at frame boundaries: 1111 for one frame, then 2222.
- Non-BCD input, load 16'hABCD: every digit shows 40.
- scan_en drop mid-frame: outputs go 0 within one cycle and frame_tick stays low.
  - A value loaded while disabled appears as soon as scan_en returns to 1, starting at digit 0.
